fetch_exc_sequencer: RTL
========================

FETCH_EXC_SEQUENCER -- requirements
Module: fetch_exc_sequencer

Interface
REQ-001 SHALL have parameters: MEM_LAT, default 3, memory read cycles per fetch (1..15); EXC_LAT, default 3, memory read cycles per exception-vector read (1..15).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have inputs: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; exec_done  in  1  execute sequencer finished; OverflowException  in  1  ALU overflow; ZeroException  in  1  divide by zero.
REQ-004 SHALL have outputs: PCWrite, IRWrite, MemRead, ControlA, ControlB, ALUOut, EPCWrite, ContOrExcep, exec_start, rst_out  out  1 each; ALUOp  out  2; ALUSrcA  out  2; ALUSrcB  out  3; IorD  out  3; PCSource  out  2; op_class  out  5  decoded instruction class.

Function
REQ-005 SHALL implement states RESET, FETCH, DECODE, DISPATCH, WAIT and EXCEPTION, with a 4-bit cycle counter.
REQ-006 RESET: all outputs 0 except rst_out=1; the first edge with reset low SHALL enter FETCH with counter=0.
REQ-007 FETCH: for MEM_LAT cycles: MemRead=1, IorD=000, ALUSrcA=01, ALUSrcB=001, ALUOp=00; in the last cycle only: PCWrite=1 and IRWrite=1, as one-cycle pulses.
REQ-008 DECODE: 1 cycle: ControlA=1, ControlB=1, ALUOut=1, ALUSrcA=01, ALUSrcB=100, ALUOp=00 (branch target).
REQ-009 DISPATCH: 1 cycle: op_class SHALL be registered from opcode/funct; a valid class SHALL pulse exec_start=1 for this cycle and go to WAIT; an invalid class (31) SHALL go to EXCEPTION with cause INVALID.
REQ-010 Decode map: opcode 0x00 with funct add 0x20, and 0x24, div 0x1a, mult 0x18, jr 0x08, mfhi 0x10, mflo 0x12, sll 0x00, slt 0x2a, sra 0x03, sub 0x22, xchg 0x05 -> classes 0..11.
REQ-011 Decode map: opcode addi 0x08, beq 0x04, bne 0x05, sllm 0x01, lb 0x20, lui 0x0f, lw 0x23, sb 0x28, sw 0x2b, j 0x02, jal 0x03 -> classes 12..22; any other opcode/funct -> 31.
REQ-012 op_class SHALL hold its value from DISPATCH until the next DISPATCH or reset.
REQ-013 WAIT: all outputs 0; on exec_done=1 with no exception flag, SHALL go to FETCH; no timeout.
REQ-014 WAIT: ZeroException=1 or OverflowException=1, sampled with or without exec_done, SHALL go to EXCEPTION; the exception SHALL win over exec_done.
REQ-015 Exception priority: ZeroException > OverflowException; the latched cause SHALL select vector IorD: INVALID=011, OVERFLOW=100, DIVZERO=101.
REQ-016 EXCEPTION counter 0: EPCWrite=1, ALUSrcA=01, ALUSrcB=001, ALUOp=01 (EPC=PC-4).
REQ-017 EXCEPTION: for EXC_LAT cycles from counter 0: MemRead=1 with the cause's IorD.
REQ-018 EXCEPTION last cycle: ContOrExcep=1, PCSource=11, PCWrite=1 as a one-cycle pulse; the next state SHALL be FETCH.
REQ-019 Exception flags outside WAIT SHALL be ignored.
REQ-020 Every control output not named for a state/cycle SHALL be 0; all outputs SHALL be registered.

Reset
REQ-021 Reset high on any edge, in any state and at any counter value, SHALL force RESET, counter=0 and op_class=0 on that edge.
REQ-022 Such a reset SHALL drop exec_start, PCWrite and EPCWrite with no further pulse; a pending WAIT is abandoned.
REQ-023 Reset held for N cycles SHALL keep rst_out=1 for all N cycles.

Structure
REQ-024 Package cpu_ctrl_pkg SHALL hold: state encoding; opcode/funct constants; op_class codes 0..22 and 31; cause/IorD vector codes; ALUSrc/ALUOp codes.
REQ-025 Opcode/funct-to-op_class mapping SHALL be a separate combinational sub-module, instr_decoder; the FSM stays in fetch_exc_sequencer.

Verification
REQ-026 Defaults, reset 2 cycles then release, opcode 0x00 funct 0x20, exec_done 2 cycles after exec_start -> PCWrite/IRWrite pulse at fetch cycle 3; DECODE; exec_start 1 cycle; op_class=0; FETCH again.
REQ-027 MEM_LAT=1 and MEM_LAT=7 -> PCWrite asserted exactly 1 cycle after, and 7 cycles after, FETCH entry respectively.
REQ-028 opcode 0x3f -> no exec_start; EPCWrite pulse; IorD=011 for 3 cycles; ContOrExcep=1 with PCWrite on the last; then FETCH.
REQ-029 div (funct 0x1a) with ZeroException=1 and OverflowException=1 together with exec_done -> cause DIVZERO, IorD=101, no return to FETCH before vector load.
REQ-030 xchg (funct 0x05) -> op_class=11, distinct from sub=10; reset asserted mid-WAIT and mid-EXCEPTION -> next cycle all outputs 0, rst_out=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the fetch/exception control sequencer.
// State, opcode/funct, class, cause and datapath-select codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_DISPATCH  = 3'd3,
    ST_WAIT      = 3'd4,
    ST_EXCEPTION = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SLLM  = 6'h01;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_XCHG = 6'h05;

  localparam logic [4:0] CL_ADD     = 5'd0;
  localparam logic [4:0] CL_AND     = 5'd1;
  localparam logic [4:0] CL_DIV     = 5'd2;
  localparam logic [4:0] CL_MULT    = 5'd3;
  localparam logic [4:0] CL_JR      = 5'd4;
  localparam logic [4:0] CL_MFHI    = 5'd5;
  localparam logic [4:0] CL_MFLO    = 5'd6;
  localparam logic [4:0] CL_SLL     = 5'd7;
  localparam logic [4:0] CL_SLT     = 5'd8;
  localparam logic [4:0] CL_SRA     = 5'd9;
  localparam logic [4:0] CL_SUB     = 5'd10;
  localparam logic [4:0] CL_XCHG    = 5'd11;
  localparam logic [4:0] CL_ADDI    = 5'd12;
  localparam logic [4:0] CL_BEQ     = 5'd13;
  localparam logic [4:0] CL_BNE     = 5'd14;
  localparam logic [4:0] CL_SLLM    = 5'd15;
  localparam logic [4:0] CL_LB      = 5'd16;
  localparam logic [4:0] CL_LUI     = 5'd17;
  localparam logic [4:0] CL_LW      = 5'd18;
  localparam logic [4:0] CL_SB      = 5'd19;
  localparam logic [4:0] CL_SW      = 5'd20;
  localparam logic [4:0] CL_J       = 5'd21;
  localparam logic [4:0] CL_JAL     = 5'd22;
  localparam logic [4:0] CL_INVALID = 5'd31;

  // Cause codes double as the IorD vector-table select.
  typedef enum logic [2:0] {
    CAUSE_INVALID  = 3'b011,
    CAUSE_OVERFLOW = 3'b100,
    CAUSE_DIVZERO  = 3'b101
  } cause_t;

  localparam logic [2:0] IORD_PC     = 3'b000;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_BRANCH = 3'b100;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] PCSRC_EXC   = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       control_a;
    logic       control_b;
    logic       alu_out;
    logic       epc_write;
    logic       cont_or_excep;
    logic       exec_start;
    logic       rst_out;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] iord;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{rst_out: 1'b1, default: '0};

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/funct to instruction-class map.
// Anything not listed decodes to the invalid class.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] op_class
);

  // R-type selects on funct, everything else on opcode
  always_comb begin
    op_class = CL_INVALID;
    if (opcode == OP_RTYPE) begin
      unique case (funct)
        FN_ADD:  op_class = CL_ADD;
        FN_AND:  op_class = CL_AND;
        FN_DIV:  op_class = CL_DIV;
        FN_MULT: op_class = CL_MULT;
        FN_JR:   op_class = CL_JR;
        FN_MFHI: op_class = CL_MFHI;
        FN_MFLO: op_class = CL_MFLO;
        FN_SLL:  op_class = CL_SLL;
        FN_SLT:  op_class = CL_SLT;
        FN_SRA:  op_class = CL_SRA;
        FN_SUB:  op_class = CL_SUB;
        FN_XCHG: op_class = CL_XCHG;
        default: op_class = CL_INVALID;
      endcase
    end else begin
      unique case (opcode)
        OP_ADDI: op_class = CL_ADDI;
        OP_BEQ:  op_class = CL_BEQ;
        OP_BNE:  op_class = CL_BNE;
        OP_SLLM: op_class = CL_SLLM;
        OP_LB:   op_class = CL_LB;
        OP_LUI:  op_class = CL_LUI;
        OP_LW:   op_class = CL_LW;
        OP_SB:   op_class = CL_SB;
        OP_SW:   op_class = CL_SW;
        OP_J:    op_class = CL_J;
        OP_JAL:  op_class = CL_JAL;
        default: op_class = CL_INVALID;
      endcase
    end
  end

endmodule

// File: rtl/fetch_exc_sequencer.sv
// Fetch/decode/dispatch sequencer with exception vectoring.
// All outputs are registered from the next-state decode.
module fetch_exc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int EXC_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       exec_done,
  input  logic       OverflowException,
  input  logic       ZeroException,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       ControlA,
  output logic       ControlB,
  output logic       ALUOut,
  output logic       EPCWrite,
  output logic       ContOrExcep,
  output logic       exec_start,
  output logic       rst_out,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] IorD,
  output logic [1:0] PCSource,
  output logic [4:0] op_class
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);
  localparam logic [3:0] EXC_LAST = 4'(EXC_LAT - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  cause_t     cause, cause_n;
  logic [4:0] cls, cls_n, dec_class;
  ctrl_t      ctrl, ctrl_n;

  instr_decoder u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .op_class (dec_class)
  );

  // Next state, counter, latched class and latched cause
  always_comb begin
    state_n = state;
    cnt_n   = 4'd0;
    cause_n = cause;
    cls_n   = cls;
    unique case (state)
      ST_RESET: state_n = ST_FETCH;
      ST_FETCH: begin
        if (cnt == MEM_LAST) state_n = ST_DECODE;
        else cnt_n = cnt + 4'd1;
      end
      ST_DECODE: begin
        state_n = ST_DISPATCH;
        cls_n   = dec_class;
        if (dec_class == CL_INVALID)
          cause_n = CAUSE_INVALID;
      end
      ST_DISPATCH: begin
        if (cls == CL_INVALID) state_n = ST_EXCEPTION;
        else state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (ZeroException) begin
          state_n = ST_EXCEPTION;
          cause_n = CAUSE_DIVZERO;
        end else if (OverflowException) begin
          state_n = ST_EXCEPTION;
          cause_n = CAUSE_OVERFLOW;
        end else if (exec_done) begin
          state_n = ST_FETCH;
        end
      end
      ST_EXCEPTION: begin
        if (cnt == EXC_LAST) state_n = ST_FETCH;
        else cnt_n = cnt + 4'd1;
      end
      default: state_n = ST_RESET;
    endcase
  end

  // Control word for the cycle being entered
  always_comb begin
    ctrl_n = '0;
    unique case (state_n)
      ST_RESET: ctrl_n.rst_out = 1'b1;
      ST_FETCH: begin
        ctrl_n.mem_read  = 1'b1;
        ctrl_n.iord      = IORD_PC;
        ctrl_n.alu_src_a = SRCA_PC;
        ctrl_n.alu_src_b = SRCB_FOUR;
        ctrl_n.alu_op    = ALUOP_ADD;
        if (cnt_n == MEM_LAST) begin
          ctrl_n.pc_write = 1'b1;
          ctrl_n.ir_write = 1'b1;
        end
      end
      ST_DECODE: begin
        ctrl_n.control_a = 1'b1;
        ctrl_n.control_b = 1'b1;
        ctrl_n.alu_out   = 1'b1;
        ctrl_n.alu_src_a = SRCA_PC;
        ctrl_n.alu_src_b = SRCB_BRANCH;
        ctrl_n.alu_op    = ALUOP_ADD;
      end
      ST_DISPATCH:
        ctrl_n.exec_start = (cls_n != CL_INVALID);
      ST_EXCEPTION: begin
        ctrl_n.mem_read = 1'b1;
        ctrl_n.iord     = cause_n;
        if (cnt_n == 4'd0) begin
          ctrl_n.epc_write = 1'b1;
          ctrl_n.alu_src_a = SRCA_PC;
          ctrl_n.alu_src_b = SRCB_FOUR;
          ctrl_n.alu_op    = ALUOP_SUB;
        end
        if (cnt_n == EXC_LAST) begin
          ctrl_n.cont_or_excep = 1'b1;
          ctrl_n.pc_source     = PCSRC_EXC;
          ctrl_n.pc_write      = 1'b1;
        end
      end
      default: ctrl_n = '0;
    endcase
  end

  // State and registered outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RESET;
      cnt   <= 4'd0;
      cause <= CAUSE_INVALID;
      cls   <= CL_ADD;
      ctrl  <= CTRL_RESET;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cause <= cause_n;
      cls   <= cls_n;
      ctrl  <= ctrl_n;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemRead     = ctrl.mem_read;
  assign ControlA    = ctrl.control_a;
  assign ControlB    = ctrl.control_b;
  assign ALUOut      = ctrl.alu_out;
  assign EPCWrite    = ctrl.epc_write;
  assign ContOrExcep = ctrl.cont_or_excep;
  assign exec_start  = ctrl.exec_start;
  assign rst_out     = ctrl.rst_out;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign IorD        = ctrl.iord;
  assign PCSource    = ctrl.pc_source;
  assign op_class    = cls;

endmodule
